// File: rtl/median_stream_filter_if.sv
// Sample-stream bundle for median_stream_filter: one unsigned sample in and
// one ranked sample out per cycle. There is no backpressure in either direction.
interface median_stream_filter_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       mode;
  logic             clear;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             full;

  modport master (
    output in_valid, in_data, mode, clear,
    input  out_valid, out_data, full
  );

  modport slave (
    input  in_valid, in_data, mode, clear,
    output out_valid, out_data, full
  );
endinterface

// File: rtl/median_stream_filter.sv
// Sliding-window rank filter. It keeps the last WIN samples and emits the
// median, minimum or maximum of the window one cycle after each accept.
module median_stream_filter #(
  parameter int WIDTH = 8,
  parameter int WIN   = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  median_stream_filter_if.slave  bus
);

  localparam int FILL_W = $clog2(WIN + 1);
  localparam int RANK_W = $clog2(WIN);

  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(WIN);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(WIN - 1);
  localparam logic [RANK_W-1:0] RANK_MIN  = '0;
  localparam logic [RANK_W-1:0] RANK_MED  = RANK_W'((WIN - 1) / 2);
  localparam logic [RANK_W-1:0] RANK_MAX  = RANK_W'(WIN - 1);

  typedef enum logic [1:0] {
    MODE_MEDIAN     = 2'd0,
    MODE_MIN        = 2'd1,
    MODE_MAX        = 2'd2,
    MODE_MEDIAN_ALT = 2'd3
  } mode_e;

  if (WIN < 3 || WIN > 9 || (WIN % 2) == 0) begin : g_bad_win
    $error("median_stream_filter: WIN must be odd and within 3..9");
  end
  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("median_stream_filter: WIDTH must be within 2..16");
  end

  logic [WIDTH-1:0]  win  [WIN];
  logic [FILL_W-1:0] fill;
  logic              out_valid_q;
  logic [WIDTH-1:0]  out_data_q;

  logic [WIDTH-1:0]  cand [WIN];
  logic [RANK_W-1:0] rank [WIN];
  logic [RANK_W-1:0] target;
  logic [WIDTH-1:0]  selected;

  // The candidate window is the window as it will look after this accept.
  always_comb begin
    cand[0] = bus.in_data;
    for (int k = 1; k < WIN; k++) begin
      cand[k] = win[k-1];
    end
  end

  // The index tie-break makes the ranks a permutation, so exactly one
  // element matches any target rank.
  always_comb begin
    for (int i = 0; i < WIN; i++) begin
      // NOTE: give every always_comb output a value before the conditional
      // logic. Otherwise some path leaves it unassigned and a latch is inferred.
      rank[i] = '0;
      for (int j = 0; j < WIN; j++) begin
        if (j != i && (cand[j] < cand[i] || (cand[j] == cand[i] && j < i))) begin
          rank[i] = rank[i] + RANK_W'(1);
        end
      end
    end
  end

  always_comb begin
    case (mode_e'(bus.mode))
      MODE_MIN:        target = RANK_MIN;
      MODE_MAX:        target = RANK_MAX;
      MODE_MEDIAN,
      MODE_MEDIAN_ALT: target = RANK_MED;
      default:         target = RANK_MED;
    endcase
  end

  always_comb begin
    selected = '0;
    for (int i = 0; i < WIN; i++) begin
      if (rank[i] == target) begin
        selected = selected | cand[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the window is a small flop array. It is reset on purpose so that
      // no sample from before the reset can be observed afterwards.
      for (int k = 0; k < WIN; k++) begin
        win[k] <= '0;
      end
      fill        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      // NOTE: state registers take non-blocking assignments, so every
      // right-hand side reads the value from before this edge.
      out_valid_q <= 1'b0;

      if (bus.in_valid) begin
        win[0] <= bus.in_data;
        for (int k = 1; k < WIN; k++) begin
          win[k] <= win[k-1];
        end
      end

      if (bus.clear) begin
        // A flush that arrives with a sample restarts the window with that
        // sample and produces no output.
        fill <= bus.in_valid ? FILL_W'(1) : '0;
      end else if (bus.in_valid) begin
        if (fill != FILL_MAX) begin
          fill <= fill + FILL_W'(1);
        end
        if (fill >= FILL_LAST) begin
          out_valid_q <= 1'b1;
          out_data_q  <= selected;
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.full      = (fill == FILL_MAX);

endmodule

// File: tb/tb_median_stream_filter.sv
// Scoreboard bench for median_stream_filter (WIDTH=8, WIN=3). A sorting
// reference model pushes the expected outputs and each output cycle pops them.
module tb_median_stream_filter;

  localparam int WIDTH = 8;
  localparam int WIN   = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  median_stream_filter_if #(.WIDTH(WIDTH)) bus ();

  median_stream_filter #(.WIDTH(WIDTH), .WIN(WIN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int mwin [WIN];
  int mfill    = 0;
  int last_out = 0;
  bit exp_v    = 1'b0;
  int q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: sort a copy of the window and pick by position.
  function automatic int pick(input int a [WIN], input logic [1:0] m);
    int s [WIN];
    int t;
    s = a;
    for (int i = 0; i < WIN - 1; i++) begin
      for (int j = 0; j < WIN - 1 - i; j++) begin
        if (s[j] > s[j+1]) begin
          t = s[j]; s[j] = s[j+1]; s[j+1] = t;
        end
      end
    end
    case (m)
      2'd1:    return s[0];
      2'd2:    return s[WIN-1];
      default: return s[(WIN-1)/2];
    endcase
  endfunction

  task automatic observe();
    int exp_d;
    check("out_valid", 32'(bus.out_valid), 32'(exp_v));
    exp_d = last_out;
    if (exp_v && q.size() > 0) begin
      exp_d    = q.pop_front();
      last_out = exp_d;
    end
    check("out_data", 32'(bus.out_data), 32'(exp_d));
    check("full", 32'(bus.full), 32'(mfill == WIN));
  endtask

  task automatic step(input logic v, input int d, input logic [1:0] m, input logic c);
    @(negedge clk);
    observe();
    bus.in_valid = v;
    bus.in_data  = d[WIDTH-1:0];
    bus.mode     = m;
    bus.clear    = c;
    exp_v = 1'b0;
    if (c) begin
      mfill = v ? 1 : 0;
      if (v) mwin[0] = d;
    end else if (v) begin
      for (int k = WIN - 1; k > 0; k--) mwin[k] = mwin[k-1];
      mwin[0] = d;
      if (mfill + 1 >= WIN) begin
        exp_v = 1'b1;
        q.push_back(pick(mwin, m));
      end
      if (mfill < WIN) mfill++;
    end
  endtask

  task automatic acc(input int d, input logic [1:0] m);
    step(1'b1, d, m, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 0, 2'd0, 1'b0);
  endtask

  task automatic clr();
    step(1'b0, 0, 2'd0, 1'b1);
  endtask

  // Reset lands 3 ns after a rising edge and is checked 1 ns later, between edges.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_data", 32'(bus.out_data), 0);
    check("rst_full", 32'(bus.full), 0);
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.mode     = 2'd0;
    bus.clear    = 1'b0;
    for (int k = 0; k < WIN; k++) mwin[k] = 0;
    mfill    = 0;
    last_out = 0;
    exp_v    = 1'b0;
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.mode     = 2'd0;
    bus.clear    = 1'b0;
    for (int k = 0; k < WIN; k++) mwin[k] = 0;

    do_reset();

    // Fill and slide: outputs 4,4,4,16 after the first two samples.
    acc(8, 2'd0); acc(1, 2'd0); acc(4, 2'd0);
    acc(16, 2'd0); acc(2, 2'd0); acc(32, 2'd0);
    idle(); idle();

    // Modes: min, max from reset, median via mode 3.
    clr(); acc(8, 2'd1); acc(1, 2'd1); acc(4, 2'd1); idle();
    do_reset();
    acc(8, 2'd2); acc(1, 2'd2); acc(4, 2'd2); idle();
    clr(); acc(8, 2'd3); acc(1, 2'd3); acc(4, 2'd3); idle();

    // Ties and extremes.
    clr(); acc(5, 2'd0); acc(5, 2'd0); acc(1, 2'd0); idle();
    clr(); acc(255, 2'd0); acc(0, 2'd0); acc(255, 2'd0); idle();
    clr(); acc(255, 2'd1); acc(0, 2'd1); acc(255, 2'd1); idle();

    // Clear mid-stream, with a sample accepted in the clear cycle.
    clr(); acc(9, 2'd0); acc(9, 2'd0);
    step(1'b1, 7, 2'd0, 1'b1);
    acc(3, 2'd0); acc(9, 2'd0); idle();

    // Gaps: idle cycles leave the window untouched.
    clr(); acc(1, 2'd0); idle(); idle(); idle();
    acc(3, 2'd0); idle(); acc(2, 2'd0); idle();

    // Asynchronous reset during a full-window stream.
    clr(); acc(10, 2'd0); acc(20, 2'd0); acc(30, 2'd0); acc(40, 2'd0);
    do_reset();
    acc(50, 2'd0); acc(60, 2'd0); acc(70, 2'd0); acc(80, 2'd0); idle();

    // Exhaustive one-hot sweep, flushing before each triple.
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        for (int c = 0; c < 8; c++) begin
          clr();
          acc(1 << a, 2'd0); acc(1 << b, 2'd0); acc(1 << c, 2'd0);
        end
      end
    end
    idle(); idle();

    check("sb_drained", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/median_stream_filter.md
# median_stream_filter

Streaming sliding-window rank filter, the clocked, parametrised successor of the 3-input combinational median circuit. It accepts one unsigned sample per valid cycle and keeps the last WIN samples. Once the window is full, it emits the median, minimum or maximum of the window one cycle after each accepted sample. It sits in the sample datapath between the input capture stage and downstream processing. It has no backpressure.

## Interface
- WIDTH, 8, sample width in bits (unsigned), legal 2..16
- WIN, 3, window length, odd, legal 3..9
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  sample strobe; in_data is accepted on every cycle it is high
- in_data  input  WIDTH  unsigned sample
- mode  input  2  selection, sampled with in_valid: 0 = median, 1 = min, 2 = max, 3 = median
- clear  input  1  synchronous window flush
- out_valid  output  1  one-cycle pulse; out_data is valid
- out_data  output  WIDTH  selected rank value
- full  output  1  window holds WIN valid samples

## Operation
- Storage:
  - Window shift register win[0..WIN-1]; win[0] holds the newest sample.
  - Fill counter fill, 0..WIN, saturates at WIN.
  - full = (fill == WIN).
- Accept (in_valid=1, clear=0):
  - Shift the window by one position, load in_data into win[0], and drop win[WIN-1].
  - fill <= min(fill+1, WIN).
- Rank computation (combinational) over the candidate window, which is in_data plus the previous win[0..WIN-2]:
  - rank(i) = number of j with x_j < x_i, or x_j == x_i and j < i.
  - Comparison is unsigned, over the full WIDTH.
  - Exactly one element holds each rank, so ties are deterministic.
- Select:
  - median = element with rank (WIN-1)/2.
  - min = element with rank 0.
  - max = element with rank WIN-1.
  - Use the mode value sampled in the accept cycle.
- Output:
  - out_valid asserts in the cycle after an accept only if that accept makes fill reach WIN (fill+1 >= WIN). In that cycle out_data is the selected value.
  - Otherwise out_valid=0 and out_data holds its previous value.
- clear=1:
  - fill <= 0, out_valid <= 0. Window contents are don't-care.
  - If in_valid is also high, the sample is accepted as the first sample of the new window (fill <= 1) and produces no output.
- Samples accepted before a clear never contribute to later outputs.
- Reset (asynchronous, any time, including mid-stream):
  - out_valid=0, out_data=0, full=0, fill=0, all win[] = 0.
  - The first output after reset requires WIN fresh accepts.
- Idle cycles (in_valid=0) change no state. out_valid=0 in the following cycle.

## Timing
- Latency: exactly 1 cycle from accept edge to out_valid/out_data.
- Throughput: one sample per cycle, back-to-back with no bubbles.
- out_valid is never high for two cycles from one accept. Continuous in_valid with a full window gives continuous out_valid.
- full updates on the same edge as fill.
- Rank logic is purely combinational between registers: one compare level of WIN×WIN comparators feeding a one-hot select.
- rst_n deassertion takes effect on the first clk edge after release. No accept occurs on an edge while rst_n=0.

## Test plan
All scenarios use WIDTH=8, WIN=3, mode=0 unless stated.
- Fill and slide: accept 8,1,4,16,2,32 on consecutive cycles.
  - No out_valid for the first two samples.
  - Then out_data = 4, 4, 4, 16 on four consecutive out_valid cycles.
  - full=1 from the third accept onward.
- Modes: window 8,1,4 with mode=1 gives out_data 1. Repeat from reset with mode=2, which gives 8. mode=3 gives 4.
- Ties and extremes:
  - 5,5,1 gives median 5.
  - 255,0,255 gives median 255; min (mode=1) gives 0.
  - Exhaustive one-hot sweep: a0,a1,a2 each over {1,2,4,…,128}, fed as triples after a clear before each triple. Each output must equal the sorted-middle value computed by the bench model.
- Clear mid-stream:
  - Accept 9,9, then clear with in_valid=1, data 7. Then accept 3,9.
  - First out_valid comes only after the 9 (median 7). full stays 0 until then.
- Gaps: accept 1, idle 3 cycles, accept 3, idle, accept 2. The single out_valid comes after the last accept, with out_data=2.
- Reset mid-operation:
  - Pull rst_n low asynchronously between edges during a full-window stream.
  - out_valid, out_data and full go to 0 immediately.
  - After release, three new accepts are needed before the next out_valid.
